ssd1306_spi_receiver: RTL and testbench

//  Receive side of the 4-wire SPI display link: a slave that decodes io_sclk/io_sdin/io_cs/io_dc/io_reset.

---
 rtl/ssd1306_pkg.sv | 16 +
 rtl/spi_slave_shifter.sv | 67 ++++++
 rtl/ssd1306_spi_receiver.sv | 165 ++++++++++++++++
 tb/tb_ssd1306_spi_receiver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// Shared definitions for the SSD1306 4-wire SPI link (receiver and display transmitter).
package ssd1306_pkg;
  localparam int COLS_DEF  = 128;
  localparam int PAGES_DEF = 8;

  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COL_A,
    ST_COL_B,
    ST_PG_A,
    ST_PG_B
  } parse_st_t;
endpackage

// File: rtl/spi_slave_shifter.sv
// SPI slave front end: input synchronizers, sclk rise detect, MSB-first shift register.
// byte_valid is combinational, one cycle wide, on the synced rise that carries bit 0.
module spi_slave_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       sdin,
  input  logic       cs,
  input  logic       dc,
  input  logic       disp_rst,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       disp_rst_n
);
  // bit order: {disp_rst, dc, cs, sdin, sclk}; idle levels are the reset values
  localparam logic [4:0] SYNC_RST = 5'b10100;

  logic [4:0][SYNC_STAGES-1:0] sync_q;
  logic [4:0]                  raw;
  logic                        sclk_s, sdin_s, cs_s, dc_s, rst_s;
  logic                        sclk_prev, rise;
  logic [6:0]                  sr;
  logic [2:0]                  bit_cnt;

  assign raw = {disp_rst, dc, cs, sdin, sclk};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) sync_q[i] <= {SYNC_STAGES{SYNC_RST[i]}};
    end else begin
      for (int i = 0; i < 5; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
    end
  end

  assign sclk_s = sync_q[0][SYNC_STAGES-1];
  assign sdin_s = sync_q[1][SYNC_STAGES-1];
  assign cs_s   = sync_q[2][SYNC_STAGES-1];
  assign dc_s   = sync_q[3][SYNC_STAGES-1];
  assign rst_s  = sync_q[4][SYNC_STAGES-1];

  assign rise = sclk_s & ~sclk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev <= 1'b0;
      sr        <= '0;
      bit_cnt   <= '0;
    end else begin
      sclk_prev <= sclk_s;
      if (!rst_s || cs_s) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (rise) begin
        sr      <= {sr[5:0], sdin_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign byte_valid = rise & ~cs_s & rst_s & (bit_cnt == 3'd7);
  assign rx_byte    = {sr, sdin_s};
  assign rx_dc      = dc_s;
  assign disp_rst_n = rst_s;
endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 SPI receive model: command port plus horizontal-mode framebuffer writes.
// Define SSD_RX_ADDR_WINDOW_EN to decode 0x21/0x22 column/page windows; otherwise full-frame linear.
module ssd1306_spi_receiver
  import ssd1306_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = COLS_DEF,
  parameter int PAGES       = PAGES_DEF,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_sclk,
  input  logic              io_sdin,
  input  logic              io_cs,
  input  logic              io_dc,
  input  logic              io_reset,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              frame_done
);
  localparam int COL_W = $clog2(COLS);
  localparam int PG_W  = $clog2(PAGES);

  logic             bv, rx_dc, disp_rst_n;
  logic [7:0]       rx_byte;
  parse_st_t        state, state_nx;
  logic             do_data, do_cmd;
  logic [COL_W-1:0] col, col_inc, col_start, col_end;
  logic [PG_W-1:0]  page, page_inc, page_start, page_end;

  spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (io_sclk),
    .sdin       (io_sdin),
    .cs         (io_cs),
    .dc         (io_dc),
    .disp_rst   (io_reset),
    .byte_valid (bv),
    .rx_byte    (rx_byte),
    .rx_dc      (rx_dc),
    .disp_rst_n (disp_rst_n)
  );

  // pointers wrap at the array edge so start>end windows run through 0 to end
  assign col_inc  = (col  == COL_W'(COLS-1)) ? '0 : col  + COL_W'(1);
  assign page_inc = (page == PG_W'(PAGES-1)) ? '0 : page + PG_W'(1);

`ifdef SSD_RX_ADDR_WINDOW_EN
  logic ld_cs, ld_ce, ld_ps, ld_pe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_start  <= '0;
      col_end    <= COL_W'(COLS-1);
      page_start <= '0;
      page_end   <= PG_W'(PAGES-1);
    end else if (!disp_rst_n) begin
      col_start  <= '0;
      col_end    <= COL_W'(COLS-1);
      page_start <= '0;
      page_end   <= PG_W'(PAGES-1);
    end else begin
      if (ld_cs) col_start  <= rx_byte[COL_W-1:0];
      if (ld_ce) col_end    <= rx_byte[COL_W-1:0];
      if (ld_ps) page_start <= rx_byte[PG_W-1:0];
      if (ld_pe) page_end   <= rx_byte[PG_W-1:0];
    end
  end
`else
  assign col_start  = '0;
  assign col_end    = COL_W'(COLS-1);
  assign page_start = '0;
  assign page_end   = PG_W'(PAGES-1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           state <= ST_IDLE;
    else if (!disp_rst_n) state <= ST_IDLE;
    else                  state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_data  = 1'b0;
    do_cmd   = 1'b0;
`ifdef SSD_RX_ADDR_WINDOW_EN
    ld_cs = 1'b0;
    ld_ce = 1'b0;
    ld_ps = 1'b0;
    ld_pe = 1'b0;
`endif
    if (bv) begin
      if (rx_dc) begin
        // data aborts any half-received argument sequence
        do_data  = 1'b1;
        state_nx = ST_IDLE;
      end else begin
        do_cmd = 1'b1;
`ifdef SSD_RX_ADDR_WINDOW_EN
        case (state)
          ST_IDLE: begin
            if (rx_byte == CMD_COL_ADDR)       state_nx = ST_COL_A;
            else if (rx_byte == CMD_PAGE_ADDR) state_nx = ST_PG_A;
          end
          ST_COL_A: begin ld_cs = 1'b1; state_nx = ST_COL_B; end
          ST_COL_B: begin ld_ce = 1'b1; state_nx = ST_IDLE;  end
          ST_PG_A:  begin ld_ps = 1'b1; state_nx = ST_PG_B;  end
          ST_PG_B:  begin ld_pe = 1'b1; state_nx = ST_IDLE;  end
          default:  state_nx = ST_IDLE;
        endcase
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      page       <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      frame_done <= 1'b0;
    end else if (!disp_rst_n) begin
      // display reset keeps the last data/command bytes visible
      col        <= '0;
      page       <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fb_we      <= do_data;
      cmd_valid  <= do_cmd;
      frame_done <= 1'b0;
      if (do_cmd) cmd_byte <= rx_byte;
      if (do_data) begin
        fb_addr  <= ADDR_W'(page) * ADDR_W'(COLS) + ADDR_W'(col);
        fb_wdata <= rx_byte;
        if (col == col_end) begin
          col <= col_start;
          if (page == page_end) begin
            page       <= page_start;
            frame_done <= 1'b1;
          end else begin
            page <= page_inc;
          end
        end else begin
          col <= col_inc;
        end
      end
`ifdef SSD_RX_ADDR_WINDOW_EN
      if (ld_ce) col  <= col_start;
      if (ld_pe) page <= page_start;
`endif
    end
  end
endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Directed bench for ssd1306_spi_receiver; expectations follow SSD_RX_ADDR_WINDOW_EN if defined.
module tb_ssd1306_spi_receiver;
`ifdef SSD_RX_ADDR_WINDOW_EN
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       io_sclk = 1'b0, io_sdin = 1'b0, io_cs = 1'b1, io_dc = 1'b0, io_reset = 1'b1;
  logic       fb_we, cmd_valid, frame_done;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, cmd_byte;

  ssd1306_spi_receiver dut (
    .clk(clk), .rst_n(rst_n), .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs),
    .io_dc(io_dc), .io_reset(io_reset), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int wa[$], wd[$], wf[$], cb[$];
  int overlap = 0, orphan = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_we) begin wa.push_back(int'(fb_addr)); wd.push_back(int'(fb_wdata)); wf.push_back(int'(frame_done)); end
      if (cmd_valid) cb.push_back(int'(cmd_byte));
      if (fb_we && cmd_valid) overlap++;
      if (frame_done && !fb_we) orphan++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) exp %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clrq();
    wa.delete(); wd.delete(); wf.delete(); cb.delete();
  endtask

  task automatic spi_bits(input logic [7:0] b, input logic d, input int n);
    if (io_cs) begin io_cs = 1'b0; tick(3); end
    for (int i = 7; i > 7 - n; i--) begin
      io_sdin = b[i];
      io_dc   = d;
      tick(2);
      io_sclk = 1'b1;
      tick(2);
      io_sclk = 1'b0;
    end
    tick(4);
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic d);
    spi_bits(b, d, 8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; io_cs = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    clrq();
  endtask

  int e2[4] = '{272, 273, 400, 401};
  int e5[5];
  int fsum;

  initial begin
    // reset state
    tick(3);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_wdata", fb_wdata, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_byte", cmd_byte, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    tick(3);

    // first data bytes land at 0, then 1
    spi_byte(8'hA5, 1'b1);
    spi_byte(8'h5A, 1'b1);
    chk("t1_nwr", wa.size(), 2);
    if (wa.size() >= 2) begin
      chk("t1_addr0", wa[0], 0);
      chk("t1_data0", wd[0], 8'hA5);
      chk("t1_addr1", wa[1], 1);
      chk("t1_data1", wd[1], 8'h5A);
    end

    // window commands then 4 data bytes
    do_reset();
    spi_byte(8'h21, 1'b0); spi_byte(8'h10, 1'b0); spi_byte(8'h11, 1'b0);
    spi_byte(8'h22, 1'b0); spi_byte(8'h02, 1'b0); spi_byte(8'h03, 1'b0);
    for (int i = 0; i < 4; i++) spi_byte(8'hF0 + 8'(i), 1'b1);
    chk("t2_ncmd", cb.size(), 6);
    if (cb.size() == 6) chk("t2_lastcmd", cb[5], 8'h03);
    chk("t2_nwr", wa.size(), 4);
    if (wa.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t2_addr%0d", i), wa[i], WIN ? e2[i] : i);
        chk($sformatf("t2_fd%0d", i), wf[i], (WIN && i == 3) ? 1 : 0);
      end
    end

    // full frame plus one
    do_reset();
    for (int i = 0; i < 1025; i++) spi_byte(8'((i * 7 + 3) & 255), 1'b1);
    chk("t3_nwr", wa.size(), 1025);
    if (wa.size() == 1025) begin
      fsum = 0;
      foreach (wf[i]) fsum += wf[i];
      chk("t3_addr500", wa[500], 500);
      chk("t3_addr1023", wa[1023], 1023);
      chk("t3_fd1023", wf[1023], 1);
      chk("t3_fdcount", fsum, 1);
      chk("t3_addr1024", wa[1024], 0);
      chk("t3_data1024", wd[1024], (1024 * 7 + 3) & 255);
    end

    // cs abort discards the partial byte
    do_reset();
    spi_bits(8'hFF, 1'b1, 5);
    io_cs = 1'b1;
    tick(4);
    spi_byte(8'h3C, 1'b0);
    chk("t4_ncmd", cb.size(), 1);
    if (cb.size() == 1) chk("t4_cmd", cb[0], 8'h3C);
    chk("t4_nwr", wa.size(), 0);

    // data aborts an argument sequence
    do_reset();
    spi_byte(8'h11, 1'b1); spi_byte(8'h22, 1'b1);
    spi_byte(8'h21, 1'b0);
    spi_byte(8'h77, 1'b1); spi_byte(8'h88, 1'b1);
    spi_byte(8'h21, 1'b0); spi_byte(8'h05, 1'b0); spi_byte(8'h06, 1'b0);
    spi_byte(8'h99, 1'b1);
    e5 = '{0, 1, 2, 3, WIN ? 5 : 4};
    chk("t5_ncmd", cb.size(), 4);
    chk("t5_nwr", wa.size(), 5);
    if (wa.size() == 5) begin
      chk("t5_data77", wd[2], 8'h77);
      for (int i = 0; i < 5; i++) chk($sformatf("t5_addr%0d", i), wa[i], e5[i]);
    end

    // display reset mid-frame
    do_reset();
    spi_byte(8'h21, 1'b0); spi_byte(8'd50, 1'b0); spi_byte(8'h7F, 1'b0);
    spi_byte(8'h22, 1'b0); spi_byte(8'h03, 1'b0); spi_byte(8'h07, 1'b0);
    spi_byte(8'hC1, 1'b1); spi_byte(8'hC2, 1'b1);
    io_reset = 1'b0;
    tick(5);
    chk("t6_rst_addr", fb_addr, 0);
    chk("t6_rst_we", fb_we, 0);
    chk("t6_hold_cmd", cmd_byte, 8'h07);
    chk("t6_hold_wdata", fb_wdata, 8'hC2);
    io_reset = 1'b1;
    tick(4);
    spi_byte(8'h5E, 1'b1);
    chk("t6_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("t6_addr_pre0", wa[0], WIN ? 434 : 0);
      chk("t6_addr_pre1", wa[1], WIN ? 435 : 1);
      chk("t6_addr_post", wa[2], 0);
      chk("t6_data_post", wd[2], 8'h5E);
    end

    chk("we_cmd_overlap", overlap, 0);
    chk("fd_without_we", orphan, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
